// File: rtl/tmds_decoder_if.sv
// TMDS channel decoder bus: deserialized words in, decoded symbols and
// alignment status out. The source of raw words uses the master view; the
// decoder uses the slave view.
interface tmds_decoder_if;
    logic [9:0] i_raw;
    logic       i_raw_valid;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_de;
    logic       o_valid;
    logic       o_locked;
    logic [3:0] o_offset;

    modport master (
        output i_raw,
        output i_raw_valid,
        input  o_data,
        input  o_ctrl,
        input  o_de,
        input  o_valid,
        input  o_locked,
        input  o_offset
    );

    modport slave (
        input  i_raw,
        input  i_raw_valid,
        output o_data,
        output o_ctrl,
        output o_de,
        output o_valid,
        output o_locked,
        output o_offset
    );
endinterface

// File: rtl/tmds_decoder.sv
// Receive-side TMDS channel decoder. Bit-slips the 10-bit deserialized stream
// until control tokens line up, then decodes each aligned word into a pixel
// byte or a 2-bit control code through a two-stage pipeline.
module tmds_decoder #(
    parameter int SEARCH_WORDS = 2048,
    parameter int LOCK_TOKENS  = 8,
    parameter int LOSS_WORDS   = 4096
) (
    input  logic          i_clk,
    input  logic          i_rst,
    tmds_decoder_if.slave bus
);

    localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
    localparam int IDLE_W = $clog2(SEARCH_WORDS + 1);
    localparam int LOSS_W = $clog2(LOSS_WORDS + 1);

    localparam logic [TOK_W-1:0]  TOK_MAX  = TOK_W'(LOCK_TOKENS);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(SEARCH_WORDS);
    localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_WORDS);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Returns {hit, code}; hit=1 when the word is one of the four control tokens.
    function automatic logic [2:0] token_lookup(input logic [9:0] w);
        logic [2:0] r;
        case (w)
            10'b1101010100: r = 3'b100;
            10'b0010101011: r = 3'b101;
            10'b0101010100: r = 3'b110;
            10'b1010101011: r = 3'b111;
            default:        r = 3'b000;
        endcase
        return r;
    endfunction

    // Undo the optional inversion, then undo the XOR/XNOR transition chain.
    function automatic logic [7:0] tmds_data_decode(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] x;
        d = q[9] ? ~q[7:0] : q[7:0];
        x = d ^ {d[6:0], 1'b0};
        return q[8] ? x : (x ^ 8'hFE);
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          offset_q, offset_d;
    logic [TOK_W-1:0]    tok_cnt_q, tok_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
    logic [9:0]          prev_raw_q, prev_raw_d;
    logic [9:0]          s1_word_q, s1_word_d;
    logic                s1_valid_q, s1_valid_d;
    logic [7:0]          data_q, data_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic                de_q, de_d;
    logic                valid_q, valid_d;
    logic                locked_q, locked_d;

    logic [19:0]         cat_s;
    logic [9:0]          aligned_s;
    logic [2:0]          s1_tok_s;

    // The window uses the post-slip offset so the first word after a slip
    // is already aligned with the new offset against the existing prev_raw.
    assign cat_s     = {bus.i_raw, prev_raw_q};
    assign aligned_s = cat_s[offset_d +: 10];
    assign s1_tok_s  = token_lookup(s1_word_q);

    // Alignment FSM: token/idle/loss counting on valid stage-1 words.
    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        tok_cnt_d  = tok_cnt_q;
        idle_cnt_d = idle_cnt_q;
        loss_cnt_d = loss_cnt_q;
        case (state_q)
            ST_SEARCH: begin
                if (s1_valid_q) begin
                    if (s1_tok_s[2]) begin
                        idle_cnt_d = {IDLE_W{1'b0}};
                        if (tok_cnt_q != TOK_MAX) begin
                            tok_cnt_d = tok_cnt_q + TOK_W'(1);
                        end else begin
                            tok_cnt_d = tok_cnt_q;
                        end
                        if (tok_cnt_d == TOK_MAX) begin
                            state_d    = ST_LOCKED;
                            tok_cnt_d  = {TOK_W{1'b0}};
                            loss_cnt_d = {LOSS_W{1'b0}};
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end else begin
                        tok_cnt_d = {TOK_W{1'b0}};
                        if (idle_cnt_q != IDLE_MAX) begin
                            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                        end else begin
                            idle_cnt_d = idle_cnt_q;
                        end
                        if (idle_cnt_d == IDLE_MAX) begin
                            state_d = ST_SLIP;
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_SLIP: begin
                offset_d   = (offset_q == 4'd9) ? 4'd0 : (offset_q + 4'd1);
                tok_cnt_d  = {TOK_W{1'b0}};
                idle_cnt_d = {IDLE_W{1'b0}};
                state_d    = ST_SEARCH;
            end
            ST_LOCKED: begin
                if (s1_valid_q) begin
                    if (s1_tok_s[2]) begin
                        loss_cnt_d = {LOSS_W{1'b0}};
                    end else begin
                        if (loss_cnt_q != LOSS_MAX) begin
                            loss_cnt_d = loss_cnt_q + LOSS_W'(1);
                        end else begin
                            loss_cnt_d = loss_cnt_q;
                        end
                        if (loss_cnt_d == LOSS_MAX) begin
                            state_d    = ST_SEARCH;
                            tok_cnt_d  = {TOK_W{1'b0}};
                            idle_cnt_d = {IDLE_W{1'b0}};
                            loss_cnt_d = {LOSS_W{1'b0}};
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d    = ST_SEARCH;
                offset_d   = 4'd0;
                tok_cnt_d  = {TOK_W{1'b0}};
                idle_cnt_d = {IDLE_W{1'b0}};
                loss_cnt_d = {LOSS_W{1'b0}};
            end
        endcase
    end

    // Stage 1: capture the aligned word; the word landing as a slip starts is dropped.
    always_comb begin
        prev_raw_d = prev_raw_q;
        s1_word_d  = s1_word_q;
        s1_valid_d = bus.i_raw_valid && (state_d != ST_SLIP);
        if (bus.i_raw_valid) begin
            prev_raw_d = bus.i_raw;
            s1_word_d  = aligned_s;
        end else begin
            prev_raw_d = prev_raw_q;
            s1_word_d  = s1_word_q;
        end
    end

    // Stage 2: token detect and data decode; outputs hold across input gaps.
    always_comb begin
        data_d   = data_q;
        ctrl_d   = ctrl_q;
        de_d     = de_q;
        locked_d = (state_d == ST_LOCKED);
        valid_d  = s1_valid_q && locked_d;
        if (s1_valid_q) begin
            if (s1_tok_s[2]) begin
                de_d   = 1'b0;
                data_d = 8'h00;
                ctrl_d = s1_tok_s[1:0];
            end else begin
                de_d   = 1'b1;
                data_d = tmds_data_decode(s1_word_q);
                ctrl_d = ctrl_q;
            end
        end else begin
            de_d   = de_q;
            data_d = data_q;
            ctrl_d = ctrl_q;
        end
    end

    // State, counters and pipeline registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_SEARCH;
            offset_q   <= 4'd0;
            tok_cnt_q  <= {TOK_W{1'b0}};
            idle_cnt_q <= {IDLE_W{1'b0}};
            loss_cnt_q <= {LOSS_W{1'b0}};
            prev_raw_q <= 10'd0;
            s1_word_q  <= 10'd0;
            s1_valid_q <= 1'b0;
            data_q     <= 8'h00;
            ctrl_q     <= 2'b00;
            de_q       <= 1'b0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            tok_cnt_q  <= tok_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            loss_cnt_q <= loss_cnt_d;
            prev_raw_q <= prev_raw_d;
            s1_word_q  <= s1_word_d;
            s1_valid_q <= s1_valid_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            de_q       <= de_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.o_data   = data_q;
    assign bus.o_ctrl   = ctrl_q;
    assign bus.o_de     = de_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_locked = locked_q;
    assign bus.o_offset = offset_q;

endmodule
